// File: rtl/shift_reg_serdes_pkg.sv
// Shared constants and helpers for the shift_reg_serdes block.
package shift_pkg;

    localparam logic LSB_FIRST = 1'b0;
    localparam logic MSB_FIRST = 1'b1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Counter must be able to hold the value W itself, hence W+1.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/shift_reg_serdes_counter.sv
// Loadable down-counter that tracks the remaining shifts of one transfer.
module serial_bit_counter
    import shift_pkg::*;
#(
    parameter int W = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic tc
);

    localparam int CW = cnt_width(W);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Decrement is gated on a non-zero count so the counter can never wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CW'(W);
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = en && (cnt_q == CW'(1));

endmodule

// File: rtl/shift_reg_serdes.sv
// Parallel-load / serial-shift register with built-in bit counter and busy/done handshake.
module shift_reg_serdes
    import shift_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         msb_first,
    input  logic         en,
    input  logic         ser_in,
    output logic         ser_out,
    output logic [W-1:0] dout,
    output logic         busy,
    output logic         done
);

    state_e       state_q;
    state_e       state_d;
    logic [W-1:0] shreg_q;
    logic [W-1:0] shreg_d;
    logic [W-1:0] shifted;
    logic         dir_q;
    logic         dir_d;
    logic         done_q;
    logic         done_d;
    logic         accept;
    logic         shift_en;
    logic         tc;

    assign accept   = load && (state_q == ST_IDLE);
    assign shift_en = en && (state_q == ST_SHIFT);

    // The serial input always enters at the end opposite to the one being emitted.
    generate
        if (W == 1) begin : g_w1
            assign shifted = ser_in;
        end else begin : g_wn
            assign shifted = (dir_q == MSB_FIRST) ? {shreg_q[W-2:0], ser_in}
                                                  : {ser_in, shreg_q[W-1:1]};
        end
    endgenerate

    serial_bit_counter #(
        .W (W)
    ) u_counter (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .en   (shift_en),
        .tc   (tc)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        if (accept) begin
            shreg_d = din;
            dir_d   = msb_first;
            state_d = ST_SHIFT;
        end else if (shift_en) begin
            shreg_d = shifted;
            if (tc) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            dir_q   <= LSB_FIRST;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    assign busy    = (state_q == ST_SHIFT);
    assign done    = done_q;
    assign dout    = shreg_q;
    assign ser_out = (dir_q == MSB_FIRST) ? shreg_q[W-1] : shreg_q[0];

endmodule

// File: tb/tb_shift_reg_serdes.sv
// Self-checking bench for shift_reg_serdes: directed transfers plus randomized traffic against a bit-stream model.
module tb_shift_reg_serdes;

    localparam int W = 32;

    logic         clk       = 1'b0;
    logic         rst       = 1'b1;
    logic         load      = 1'b0;
    logic [W-1:0] din       = '0;
    logic         msb_first = 1'b0;
    logic         en        = 1'b0;
    logic         ser_in    = 1'b0;
    logic         ser_out;
    logic [W-1:0] dout;
    logic         busy;
    logic         done;

    int   checks   = 0;
    int   errors   = 0;
    logic loopMode = 1'b0;

    shift_reg_serdes #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .din       (din),
        .msb_first (msb_first),
        .en        (en),
        .ser_in    (ser_in),
        .ser_out   (ser_out),
        .dout      (dout),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Model: a transfer is the loaded word plus the list of bits captured so far, in arrival order.
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic         m_dir  = 1'b0;
    logic [W-1:0] m_din  = '0;
    logic [W-1:0] m_dout = '0;
    logic [W-1:0] m_cap  = '0;
    int           m_k    = 0;
    logic [W-1:0] expWord;

    function automatic logic [W-1:0] expDout();
        logic [W-1:0] r;
        r = '0;
        if (!m_busy) return m_dout;
        for (int i = 0; i < W; i++) begin
            if (!m_dir) r[i] = (i < W - m_k) ? m_din[i + m_k] : m_cap[i - (W - m_k)];
            else        r[i] = (i >= m_k)    ? m_din[i - m_k] : m_cap[m_k - 1 - i];
        end
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_dir  = 1'b0;
            m_dout = '0;
            m_k    = 0;
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (load) begin
                    m_din  = din;
                    m_dir  = msb_first;
                    m_k    = 0;
                    m_busy = 1'b1;
                end
            end else if (en) begin
                m_cap[m_k] = ser_in;
                m_k++;
                if (m_k == W) begin
                    m_dout = expDout();
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        expWord = expDout();
        checkOutput("model_busy", W'(busy), W'(m_busy));
        checkOutput("model_done", W'(done), W'(m_done));
        checkOutput("model_dout", dout, expWord);
        checkOutput("model_ser_out", W'(ser_out), W'(m_dir ? expWord[W-1] : expWord[0]));
    end

    task automatic applyStimulus(input logic l, input logic [W-1:0] d, input logic m,
                                 input logic e, input logic s);
        load      = l;
        din       = d;
        msb_first = m;
        en        = e;
        ser_in    = loopMode ? ser_out : s;
        @(posedge clk);
        #1;
    endtask

    task automatic runTransfer(input logic [W-1:0] word, input logic msb, input logic s,
                               input int stallAt, input int stallLen, input int midLoadAt,
                               output int edges, output int ones, output logic [W-1:0] doneWord);
        int   shifts;
        int   stalled;
        bit   got;
        logic e;
        logic midLoad;
        shifts   = 0;
        stalled  = 0;
        got      = 0;
        edges    = 0;
        ones     = 0;
        doneWord = '0;
        applyStimulus(1'b1, word, msb, 1'b1, s);
        checkOutput("busy_after_load", W'(busy), W'(1));
        while (!got && edges < 2 * W) begin
            e = !(shifts == stallAt && stalled < stallLen);
            if (!e) begin
                stalled++;
                checkOutput("stall_busy", W'(busy), W'(1));
                checkOutput("stall_ser_out", W'(ser_out), W'(msb ? word[W-1-shifts] : word[shifts]));
            end else begin
                ones += int'(ser_out);
            end
            midLoad = (edges == midLoadAt);
            applyStimulus(midLoad, midLoad ? 32'h12345678 : $urandom, 1'($urandom), e, s);
            edges++;
            if (e) shifts++;
            if (done) begin
                got      = 1;
                doneWord = dout;
            end
        end
        if (!got) checkOutput("done_timeout", W'(0), W'(1));
    endtask

    int           edges;
    int           ones;
    logic [W-1:0] dw;

    initial begin
        $display("[TB] start");
        #12 rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_busy", W'(busy), W'(0));
        checkOutput("reset_done", W'(done), W'(0));
        checkOutput("reset_dout", dout, W'(0));
        checkOutput("reset_ser_out", W'(ser_out), W'(0));

        // Reset in the middle of a transfer.
        applyStimulus(1'b1, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b1);
        repeat (10) applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
        checkOutput("midreset_busy_before", W'(busy), W'(1));
        rst = 1'b1;
        #1;
        checkOutput("midreset_busy", W'(busy), W'(0));
        checkOutput("midreset_dout", dout, W'(0));
        checkOutput("midreset_ser_out", W'(ser_out), W'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("midreset_done", W'(done), W'(0));
        @(posedge clk);
        #1;
        checkOutput("midreset_done_after", W'(done), W'(0));
        checkOutput("midreset_busy_after", W'(busy), W'(0));

        // LSB-first, ser_in=0.
        runTransfer(32'h00000FFF, 1'b0, 1'b0, -1, 0, -1, edges, ones, dw);
        checkOutput("lsb_edges", W'(edges), W'(32));
        checkOutput("lsb_ones", W'(ones), W'(12));
        checkOutput("lsb_dout", dw, 32'h0);

        // MSB-first, ser_in=1.
        runTransfer(32'h80000001, 1'b1, 1'b1, -1, 0, -1, edges, ones, dw);
        checkOutput("msb_edges", W'(edges), W'(32));
        checkOutput("msb_ones", W'(ones), W'(2));
        checkOutput("msb_dout", dw, 32'hFFFFFFFF);

        // Five-cycle stall after the 8th shift.
        runTransfer(32'h00000FFF, 1'b0, 1'b0, 8, 5, -1, edges, ones, dw);
        checkOutput("stall_edges", W'(edges), W'(37));
        checkOutput("stall_ones", W'(ones), W'(12));
        checkOutput("stall_dout", dw, 32'h0);

        // Loopback in both directions.
        loopMode = 1'b1;
        runTransfer(32'hDEADBEEF, 1'b0, 1'b0, -1, 0, -1, edges, ones, dw);
        checkOutput("loop_lsb_dout", dw, 32'hDEADBEEF);
        runTransfer(32'hDEADBEEF, 1'b1, 1'b0, -1, 0, -1, edges, ones, dw);
        checkOutput("loop_msb_dout", dw, 32'hDEADBEEF);

        // Load while busy is ignored, then a back-to-back load in the done cycle.
        runTransfer(32'hCAFEF00D, 1'b0, 1'b0, -1, 0, 5, edges, ones, dw);
        checkOutput("busyload_edges", W'(edges), W'(32));
        checkOutput("busyload_dout", dw, 32'hCAFEF00D);
        checkOutput("b2b_done_cycle", W'(done), W'(1));
        runTransfer(32'h0F0F1234, 1'b1, 1'b0, -1, 0, -1, edges, ones, dw);
        checkOutput("b2b_edges", W'(edges), W'(32));
        checkOutput("b2b_dout", dw, 32'h0F0F1234);
        loopMode = 1'b0;

        // Randomized traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                rst = 1'b1;
                #2;
                rst = 1'b0;
            end
            applyStimulus($urandom_range(0, 3) == 0, $urandom, 1'($urandom),
                          $urandom_range(0, 4) != 0, 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_reg_serdes.md
Name: shift_reg_serdes

Overview:
- Parametrised parallel-load / serial-shift register with a built-in bit counter and a busy/done handshake.
- Serialises a W-bit word onto ser_out and simultaneously deserialises ser_in into the same register.
- Shift direction is selectable per transfer (LSB-first or MSB-first); the shift can be paused with en.
- Sits in front of the bit-serial comparator/adder datapaths and sequences a full word transfer with no external counter.

Parameters:
- W, 32, register width in bits (W >= 1).
- CW, $clog2(W+1), bit-counter width; derived, must not be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- load  input  1  request to parallel-load din and start a transfer; honoured only when busy=0.
- din  input  W  parallel load word.
- msb_first  input  1  direction for the transfer, sampled on the accepted load (1 = MSB first).
- en  input  1  shift enable while busy; 0 holds all state.
- ser_in  input  1  serial input, inserted at the vacated end on each shift.
- ser_out  output  1  current serial output bit.
- dout  output  W  register contents (captured serial word once done).
- busy  output  1  transfer in progress.
- done  output  1  single-cycle pulse: transfer complete.

Behaviour:
- Reset (async, rst=1): shreg=0, cnt=0, dir_q=0, busy=0, done=0; therefore ser_out=0 and dout=0. rst overrides every input, including mid-transfer; a transfer in progress is abandoned with no done pulse.
- Two states, encoded by busy:
  - IDLE (busy=0): load=1 at a clock edge -> shreg<=din, dir_q<=msb_first, cnt<=W, busy<=1.
  - SHIFT (busy=1): at each edge with en=1, one shift and cnt<=cnt-1.
    - dir_q=0: shreg<={ser_in, shreg[W-1:1]}.
    - dir_q=1: shreg<={shreg[W-2:0], ser_in}.
    - For W=1: shreg<=ser_in.
    - If en=0: shreg, cnt and busy hold.
  - Completion: the shift that takes cnt from 1 to 0 also sets busy<=0 and done<=1. done is high for exactly one cycle.
- ser_out is combinational from registered state: dir_q ? shreg[W-1] : shreg[0].
  - Bit 0 of the word is visible in the cycle after load is accepted.
  - Bit k is visible after k enabled shifts.
- Latency: with en held at 1, done is high in the cycle starting W edges after the load edge. Each en=0 cycle adds one cycle.
- After done, dout holds the W ser_in bits sampled on the W shifts:
  - LSB-first: first sampled bit ends in dout[0].
  - MSB-first: first sampled bit ends in dout[W-1].
- Loopback (ser_in=ser_out) restores din in dout after done.
- load while busy=1 is ignored (no restart, no effect on shreg, cnt or dir_q).
- load in the same cycle done is high is accepted, giving back-to-back transfers with zero idle cycles.
- msb_first and din are don't-care except on an accepted load edge.
- cnt never wraps: it decrements only while busy, and busy clears at 0.

Decomposition:
- Package shift_pkg:
  - localparams LSB_FIRST=1'b0, MSB_FIRST=1'b1.
  - function for counter width (clog2(W+1)).
- One sub-module is natural: serial_bit_counter.
  - Loadable CW-bit down-counter with enable.
  - Outputs a terminal-count flag (cnt==1 && en).
  - Drives busy clear and done set.
- The shift datapath stays in the top module.

Test Plan:
1. Reset mid-transfer: load 32'hA5A5A5A5, 10 enabled shifts, pulse rst -> busy=0, done never pulses, dout=0, ser_out=0 immediately (async).
2. LSB-first: load 32'h00000FFF, msb_first=0, en=1, ser_in=0 -> ser_out=1 for the first 12 cycles, then 0 for 20 cycles; done pulses once, 32 edges after load; dout=32'h0.
3. MSB-first: load 32'h80000001, msb_first=1, ser_in=1 -> ser_out sequence 1, thirty 0s, 1; dout=32'hFFFFFFFF at done.
4. Stall: as test 2 but en=0 for 5 cycles after the 8th shift -> ser_out holds the bit-8 value during the stall; done arrives at edge 37; busy stays 1 throughout the stall.
5. Loopback: ser_in tied to ser_out, load 32'hDEADBEEF, both directions -> dout=32'hDEADBEEF at done.
6. Protocol: load 32'h12345678 while busy (cycle 5) is ignored (dout after done reflects only the first load); load asserted in the done cycle starts the next transfer with busy staying 1.
